ravenoc_vc_buffer: RTL and testbench

- Multi-channel input buffer for the RaveNoC router ports.
- Holds N_VC independent FIFO lanes (virtual channels) over one write port and one read port; each access is steered by a VC index.
- Per-VC status outputs (full, empty, almost-full, occupancy) feed credit and arbitration logic.
- An error pulse flags illegal accesses: overflow, underflow, and out-of-range VC index.

---
 rtl/ravenoc_pkg.sv | 28 ++
 rtl/ravenoc_vc_lane.sv | 72 +++++++
 rtl/ravenoc_vc_buffer.sv | 78 +++++++
 tb/tb_ravenoc_vc_buffer.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/ravenoc_pkg.sv
// Shared types and defaults for the RaveNoC virtual-channel input buffer.
package ravenoc_pkg;

   localparam int N_VC_DEF   = 3;
   localparam int SLOTS_DEF  = 4;
   localparam int WIDTH_DEF  = 34;
   localparam int STAT_CNT_W = 16;

   // Width of a VC index; a single lane still needs one select bit.
   function automatic int vc_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int VC_W_DEF = vc_width(N_VC_DEF);

   typedef logic [VC_W_DEF-1:0]  vc_id_t;
   typedef logic [WIDTH_DEF-1:0] flit_t;

   // Per-lane status; count is zero-extended to a generous fixed width so the
   // struct stays independent of the lane depth.
   typedef struct packed {
      logic                  full;
      logic                  empty;
      logic                  afull;
      logic [STAT_CNT_W-1:0] count;
   } lane_status_t;

endpackage

// File: rtl/ravenoc_vc_lane.sv
// One virtual-channel lane: a circular FIFO of SLOTS flits with explicit
// pointer wrap, so any depth works.
module ravenoc_vc_lane
   import ravenoc_pkg::*;
#(
   parameter int SLOTS    = SLOTS_DEF,
   parameter int WIDTH    = WIDTH_DEF,
   parameter int AFULL_TH = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic             pop_ok_when_full,
   input  logic [WIDTH-1:0] data,
   output logic             push_ok,
   output logic             pop_ok,
   output logic [WIDTH-1:0] head,
   output lane_status_t     status
);

   localparam int PTR_W = $clog2(SLOTS);
   localparam int CNT_W = $clog2(SLOTS + 1);
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(SLOTS - 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(SLOTS);
   localparam logic [CNT_W-1:0] AFULL_CNT = CNT_W'(AFULL_TH);

   logic [WIDTH-1:0] mem [SLOTS];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic             is_full;
   logic             is_empty;

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
   endfunction

   assign is_full  = (count == FULL_CNT);
   assign is_empty = (count == '0);

   // A pop never sees a same-cycle push (no bypass); a push into a full lane
   // is only allowed when the head leaves in the same cycle.
   assign pop_ok  = pop && !is_empty;
   assign push_ok = push && (!is_full || (pop_ok_when_full && pop_ok));

   // Pointer and occupancy bookkeeping.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= next_ptr(wr_ptr);
         if (pop_ok)  rd_ptr <= next_ptr(rd_ptr);
         if (push_ok && !pop_ok)      count <= count + CNT_W'(1);
         else if (!push_ok && pop_ok) count <= count - CNT_W'(1);
      end
   end

   // Flit storage; contents are meaningless until written, so no reset.
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= data;
   end

   assign head   = is_empty ? '0 : mem[rd_ptr];
   assign status = '{full:  is_full,
                     empty: is_empty,
                     afull: (count >= AFULL_CNT),
                     count: STAT_CNT_W'(count)};

endmodule

// File: rtl/ravenoc_vc_buffer.sv
// Multi-VC router input buffer: VC decode and range check, one lane per VC,
// head-flit mux, packed occupancy and a registered error pulse.
module ravenoc_vc_buffer
   import ravenoc_pkg::*;
#(
   parameter int N_VC     = N_VC_DEF,
   parameter int SLOTS    = SLOTS_DEF,
   parameter int WIDTH    = WIDTH_DEF,
   parameter int AFULL_TH = 3,
   localparam int VC_W    = vc_width(N_VC),
   localparam int CNT_W   = $clog2(SLOTS + 1)
) (
   input  logic                    clk,
   input  logic                    arst,
   input  logic                    write_i,
   input  logic [VC_W-1:0]         wr_vc_i,
   input  logic [WIDTH-1:0]        data_i,
   input  logic                    read_i,
   input  logic [VC_W-1:0]         rd_vc_i,
   output logic [WIDTH-1:0]        data_o,
   output logic                    error_o,
   output logic [N_VC-1:0]         full_o,
   output logic [N_VC-1:0]         empty_o,
   output logic [N_VC-1:0]         afull_o,
   output logic [N_VC*CNT_W-1:0]   occ_o
);

   localparam logic [31:0] N_VC_U = 32'(N_VC);

   logic               wr_in_range;
   logic               rd_in_range;
   logic [N_VC-1:0]    push_ok;
   logic [N_VC-1:0]    pop_ok;
   logic [WIDTH-1:0]   head [N_VC];
   lane_status_t       status [N_VC];

   assign wr_in_range = (32'(wr_vc_i) < N_VC_U);
   assign rd_in_range = (32'(rd_vc_i) < N_VC_U);

   for (genvar k = 0; k < N_VC; k++) begin : g_lane
      ravenoc_vc_lane #(
         .SLOTS    (SLOTS),
         .WIDTH    (WIDTH),
         .AFULL_TH (AFULL_TH)
      ) u_lane (
         .clk              (clk),
         .rst              (arst),
         .push             (write_i && wr_in_range && (wr_vc_i == VC_W'(k))),
         .pop              (read_i && rd_in_range && (rd_vc_i == VC_W'(k))),
         .pop_ok_when_full (1'b1),
         .data             (data_i),
         .push_ok          (push_ok[k]),
         .pop_ok           (pop_ok[k]),
         .head             (head[k]),
         .status           (status[k])
      );

      assign full_o[k]                 = status[k].full;
      assign empty_o[k]                = status[k].empty;
      assign afull_o[k]                = status[k].afull;
      assign occ_o[k*CNT_W +: CNT_W]   = status[k].count[CNT_W-1:0];
   end

   // Head flit of the selected lane; out-of-range selects read as zero.
   always_comb begin
      data_o = '0;
      for (int k = 0; k < N_VC; k++) begin
         if (rd_in_range && (rd_vc_i == VC_W'(k))) data_o = head[k];
      end
   end

   // Any requested operation that no lane accepted is an illegal access.
   always_ff @(posedge clk) begin
      if (arst) error_o <= 1'b0;
      else      error_o <= (write_i && !(|push_ok)) || (read_i && !(|pop_ok));
   end

endmodule

// File: tb/tb_ravenoc_vc_buffer.sv
// Bench for ravenoc_vc_buffer: directed scenarios followed by random traffic,
// all checked against a queue-per-lane reference model.
module tb_ravenoc_vc_buffer;
   import ravenoc_pkg::*;

   logic        clk;
   logic        arst;
   logic        write_i;
   vc_id_t      wr_vc_i;
   flit_t       data_i;
   logic        read_i;
   vc_id_t      rd_vc_i;
   flit_t       data_o;
   logic        error_o;
   logic [2:0]  full_o;
   logic [2:0]  empty_o;
   logic [2:0]  afull_o;
   logic [8:0]  occ_o;

   int total = 0;
   int bad   = 0;

   // Reference model: one FIFO queue per lane plus the expected error flag.
   flit_t q [3][$];
   logic  exp_err = 1'b0;

   ravenoc_vc_buffer dut (
      .clk     (clk),
      .arst    (arst),
      .write_i (write_i),
      .wr_vc_i (wr_vc_i),
      .data_i  (data_i),
      .read_i  (read_i),
      .rd_vc_i (rd_vc_i),
      .data_o  (data_o),
      .error_o (error_o),
      .full_o  (full_o),
      .empty_o (empty_o),
      .afull_o (afull_o),
      .occ_o   (occ_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_status();
      logic [2:0] ef, ee, ea;
      logic [8:0] eo;
      for (int k = 0; k < 3; k++) begin
         int n;
         n = q[k].size();
         ef[k] = (n == 4);
         ee[k] = (n == 0);
         ea[k] = (n >= 3);
         eo[k*3 +: 3] = 3'(n);
      end
      chk("full_o",  64'(full_o),  64'(ef));
      chk("empty_o", 64'(empty_o), 64'(ee));
      chk("afull_o", 64'(afull_o), 64'(ea));
      chk("occ_o",   64'(occ_o),   64'(eo));
      chk("error_o", 64'(error_o), 64'(exp_err));
   endtask

   // One clock cycle: drive, check the head flit before the edge, advance the
   // model, then check every status output after the edge.
   task automatic step(input logic rst, input logic w, input int wvc, input flit_t d,
                       input logic r, input int rvc);
      flit_t exp_d;
      logic  rd_acc, wr_acc;
      arst    = rst;
      write_i = w;
      wr_vc_i = 2'(wvc);
      data_i  = d;
      read_i  = r;
      rd_vc_i = 2'(rvc);
      #1;
      if (!rst) begin
         exp_d = '0;
         if (rvc < 3) begin
            if (q[rvc].size() > 0) exp_d = q[rvc][0];
         end
         chk("data_o", 64'(data_o), 64'(exp_d));
      end
      if (rst) begin
         for (int k = 0; k < 3; k++) q[k].delete();
         exp_err = 1'b0;
      end else begin
         rd_acc = 1'b0;
         wr_acc = 1'b0;
         if (r && rvc < 3) rd_acc = (q[rvc].size() > 0);
         if (w && wvc < 3) wr_acc = (q[wvc].size() < 4) || (rd_acc && rvc == wvc);
         exp_err = (w && !wr_acc) || (r && !rd_acc);
         if (rd_acc) void'(q[rvc].pop_front());
         if (wr_acc) q[wvc].push_back(d);
      end
      @(posedge clk);
      #1;
      check_status();
   endtask

   initial begin
      logic [63:0] rnd;
      arst = 1'b0; write_i = 1'b0; read_i = 1'b0;
      wr_vc_i = '0; rd_vc_i = '0; data_i = '0;
      @(negedge clk);

      // Reset, then an idle cycle.
      step(1, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0);

      // Fill VC1 to full, then one overflow attempt and an idle cycle.
      for (int i = 1; i <= 4; i++) step(0, 1, 1, flit_t'(i), 0, 0);
      step(0, 1, 1, flit_t'(5), 0, 0);
      chk("vc1_occ_after_overflow", 64'(occ_o[5:3]), 64'd4);
      step(0, 0, 0, 0, 0, 1);

      // Drain VC1 in order, then one underflow attempt.
      for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1, 1);
      step(0, 0, 0, 0, 1, 1);
      chk("vc1_empty_after_underflow", 64'(empty_o[1]), 64'd1);
      step(0, 0, 0, 0, 0, 0);

      // Interleaved push/pop on VC0 exercising pointer wrap.
      for (int i = 0; i < 10; i++) begin
         step(0, 1, 0, flit_t'(32'h10 + i), 0, 0);
         step(0, 0, 0, 0, 1, 0);
      end

      // Full VC2 with simultaneous write and read of the same lane.
      for (int i = 0; i < 4; i++) step(0, 1, 2, flit_t'(32'h20 + i), 0, 2);
      step(0, 1, 2, flit_t'(32'hAA), 1, 2);
      chk("vc2_occ_after_swap", 64'(occ_o[8:6]), 64'd4);
      for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1, 2);

      // Out-of-range VC index for write and for read.
      step(0, 1, 0, flit_t'(32'h5), 0, 0);
      step(0, 1, 3, flit_t'(32'h33), 0, 0);
      step(0, 0, 0, 0, 1, 3);
      step(0, 0, 0, 0, 0, 0);

      // Reset while VC0 holds flits and a write is in flight.
      step(0, 1, 0, flit_t'(32'h66), 0, 0);
      step(1, 1, 0, flit_t'(32'h77), 0, 0);
      chk("empty_after_reset", 64'(empty_o), 64'd7);
      step(0, 0, 0, 0, 1, 0);

      // Random traffic with occasional resets.
      for (int i = 0; i < 600; i++) begin
         rnd = {$urandom(), $urandom()};
         step(($urandom_range(0, 79) == 0),
              ($urandom_range(0, 9) < 6), int'($urandom_range(0, 3)), rnd[33:0],
              ($urandom_range(0, 9) < 5), int'($urandom_range(0, 3)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
